// File: rtl/mc_main_fsm_if.sv
// Handshake/control bundle between the instruction decoder side and mc_main_fsm.
// Inputs: Op, Funct, Instr7_4, MemReady. Outputs: datapath controls, MulBusy, Fault, state.
interface mc_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Instr7_4;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       MulBusy;
    logic       Fault;
    logic [3:0] state;

    modport master (
        output Op, Funct, Instr7_4, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
        input  ALUSrcB, ResultSrc, ALUOp, MulBusy, Fault, state
    );

    modport slave (
        input  Op, Funct, Instr7_4, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
        output ALUSrcB, ResultSrc, ALUOp, MulBusy, Fault, state
    );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM core: memory wait handshake with
// watchdog trap to FAULT, optional multi-cycle MUL state (macro MC_MUL_EN).
// Ports: clk, reset (async, active-low), bus (mc_main_fsm_if.slave):
//   Op/Funct/Instr7_4/MemReady in; datapath controls, MulBusy, Fault, state out.
module mc_main_fsm #(
    parameter int MUL_CYCLES = 4,
    parameter int WAIT_MAX   = 255,
    parameter int CNT_W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    mc_main_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        MULEX  = 4'd10,
        FAULT  = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] WMAX = CNT_W'(WAIT_MAX);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;
    logic             wd_trip;
    logic             is_mul;

    assign mem_wait = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    // MemReady=1 in the trip cycle wins: the access completes normally.
    assign wd_trip  = (WAIT_MAX != 0) && !bus.MemReady && (wait_cnt == WMAX);

`ifdef MC_MUL_EN
    localparam logic [CNT_W-1:0] MULN = CNT_W'(MUL_CYCLES);
    logic [CNT_W-1:0] mul_cnt;
    assign is_mul = (bus.Funct[4:1] == 4'b0000) && (bus.Instr7_4 == 4'b1001);
`else
    logic unused_mul_bits;
    assign is_mul          = 1'b0;
    assign unused_mul_bits = ^{bus.Funct[4:1], bus.Instr7_4};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur      <= FETCH;
            wait_cnt <= '0;
`ifdef MC_MUL_EN
            mul_cnt  <= '0;
`endif
        end else begin
            // Counts consecutive stalled cycles; saturates instead of wrapping.
            if (!mem_wait || bus.MemReady)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + CNT_W'(1);

`ifdef MC_MUL_EN
            if (cur == DECODE)
                mul_cnt <= CNT_W'(1);
            else if (cur == MULEX)
                mul_cnt <= mul_cnt + CNT_W'(1);
`endif

            unique case (cur)
                FETCH: begin
                    if (bus.MemReady)  cur <= DECODE;
                    else if (wd_trip)  cur <= FAULT;
                end
                DECODE: begin
                    unique case (bus.Op)
                        2'b01: cur <= MEMADR;
                        2'b10: cur <= BRANCH;
                        2'b11: cur <= FAULT;
                        default: begin
                            if (bus.Funct[5]) cur <= EXECI;
                            else if (is_mul)  cur <= MULEX;
                            else              cur <= EXECR;
                        end
                    endcase
                end
                MEMADR: cur <= bus.Funct[0] ? MEMRD : MEMWR;
                MEMRD: begin
                    if (bus.MemReady)  cur <= MEMWB;
                    else if (wd_trip)  cur <= FAULT;
                end
                MEMWB: cur <= FETCH;
                MEMWR: begin
                    if (bus.MemReady)  cur <= FETCH;
                    else if (wd_trip)  cur <= FAULT;
                end
                EXECR:  cur <= ALUWB;
                EXECI:  cur <= ALUWB;
                ALUWB:  cur <= FETCH;
                BRANCH: cur <= FETCH;
`ifdef MC_MUL_EN
                MULEX: begin
                    if (mul_cnt == MULN) cur <= ALUWB;
                end
`endif
                FAULT:  cur <= FAULT;
                default: cur <= FAULT;
            endcase
        end
    end

    // Decoded from state rather than registered so the FETCH controls are
    // valid in the first cycle after reset and IRWrite/NextPC track MemReady.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp     = 1'b0;
        bus.MulBusy   = 1'b0;
        bus.Fault     = 1'b0;
        bus.state     = cur;
        if (reset) begin
            case (cur)
                FETCH: begin
                    bus.IRWrite   = bus.MemReady;
                    bus.NextPC    = bus.MemReady;
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                DECODE: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                MEMADR: bus.ALUSrcB = 2'b01;
                MEMRD:  bus.AdrSrc  = 1'b1;
                MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegW      = 1'b1;
                end
                MEMWR: begin
                    bus.AdrSrc = 1'b1;
                    bus.MemW   = 1'b1;
                end
                EXECR: bus.ALUOp = 1'b1;
                EXECI: begin
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 1'b1;
                end
                ALUWB: bus.RegW = 1'b1;
                BRANCH: begin
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.Branch    = 1'b1;
                end
`ifdef MC_MUL_EN
                MULEX: begin
                    bus.ALUOp   = 1'b1;
                    bus.MulBusy = 1'b1;
                end
`endif
                FAULT: bus.Fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
